// File: rtl/quadtree_switch_allocator.sv
// Quadtree router switch allocator: per-output round-robin unicast arbitration
// plus a single multicast owner that reserves outputs until it can send atomically.
module quadtree_switch_allocator #(
  parameter int NUM_PORT = 5,
  parameter int IDX_W    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORT-1:0]          req_valid,
  input  logic [NUM_PORT*NUM_PORT-1:0] req_port,
  input  logic [NUM_PORT-1:0]          out_ready,
  output logic [NUM_PORT-1:0]          grant,
  output logic [NUM_PORT-1:0]          out_valid,
  output logic [NUM_PORT*IDX_W-1:0]    out_sel,
  output logic                         mc_busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q [NUM_PORT];
  logic [IDX_W-1:0]    rr_ptr_d [NUM_PORT];
  logic [IDX_W-1:0]    mc_ptr_q, mc_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_PORT-1:0] resv_q, resv_d;

  logic [NUM_PORT-1:0] port [NUM_PORT];
  logic [NUM_PORT-1:0] uc, mc, uc_eff, mask;
  logic [NUM_PORT-1:0] owner_port;
  logic                owner_req, owner_ok, mc_fire, hold;
  logic [NUM_PORT-1:0] found;
  logic [IDX_W-1:0]    win [NUM_PORT];
  logic                mc_found;
  logic [IDX_W-1:0]    mc_sel;

  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] a,
    input int               k
  );
    int s;
    s = int'(a) + k;
    if (s >= NUM_PORT) s = s - NUM_PORT;
    return IDX_W'(s);
  endfunction

  assign hold = (state_q == HOLD);

  always_comb begin
    uc         = '0;
    mc         = '0;
    owner_port = '0;
    owner_req  = 1'b0;
    for (int i = 0; i < NUM_PORT; i++) begin
      port[i] = req_port[i*NUM_PORT +: NUM_PORT];
      uc[i]   = req_valid[i] && ($countones(port[i]) == 1);
      mc[i]   = req_valid[i] && ($countones(port[i]) >= 2);
      if (IDX_W'(i) == owner_q) begin
        owner_port = port[i];
        owner_req  = req_valid[i];
      end
    end
  end

  // The owner must still present the exact route it reserved with.
  assign owner_ok = hold && owner_req && (owner_port == resv_q);
  assign mc_fire  = owner_ok && ((out_ready & resv_q) == resv_q);
  assign mask     = hold ? resv_q : '0;

  always_comb begin
    uc_eff = uc;
    if (hold) uc_eff[owner_q] = 1'b0;
  end

  always_comb begin
    for (int o = 0; o < NUM_PORT; o++) begin
      found[o] = 1'b0;
      win[o]   = '0;
      if (!mask[o] && out_ready[o]) begin
        for (int k = 0; k < NUM_PORT; k++) begin
          if (!found[o] && uc_eff[wrap_add(rr_ptr_q[o], k)] &&
              port[wrap_add(rr_ptr_q[o], k)][o]) begin
            found[o] = 1'b1;
            win[o]   = wrap_add(rr_ptr_q[o], k);
          end
        end
      end
    end
  end

  always_comb begin
    mc_found = 1'b0;
    mc_sel   = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      if (!mc_found && mc[wrap_add(mc_ptr_q, k)]) begin
        mc_found = 1'b1;
        mc_sel   = wrap_add(mc_ptr_q, k);
      end
    end
  end

  always_comb begin
    grant     = '0;
    out_valid = '0;
    out_sel   = '0;
    if (!rst) begin
      for (int o = 0; o < NUM_PORT; o++) begin
        if (found[o]) begin
          grant[win[o]] = 1'b1;
          out_valid[o]  = 1'b1;
          out_sel[o*IDX_W +: IDX_W] = win[o];
        end
        if (mc_fire && resv_q[o]) begin
          out_valid[o] = 1'b1;
          out_sel[o*IDX_W +: IDX_W] = owner_q;
        end
      end
      if (mc_fire) grant[owner_q] = 1'b1;
    end
  end

  assign mc_busy = hold;

  always_comb begin
    state_d  = state_q;
    mc_ptr_d = mc_ptr_q;
    owner_d  = owner_q;
    resv_d   = resv_q;
    for (int o = 0; o < NUM_PORT; o++) begin
      rr_ptr_d[o] = found[o] ? wrap_add(win[o], 1) : rr_ptr_q[o];
    end
    unique case (state_q)
      IDLE: begin
        if (mc_found) begin
          state_d  = HOLD;
          owner_d  = mc_sel;
          resv_d   = port[mc_sel];
          mc_ptr_d = wrap_add(mc_sel, 1);
        end
      end
      HOLD: begin
        if (!owner_ok || mc_fire) begin
          state_d = IDLE;
          resv_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mc_ptr_q <= '0;
      owner_q  <= '0;
      resv_q   <= '0;
      for (int o = 0; o < NUM_PORT; o++) rr_ptr_q[o] <= '0;
    end else begin
      state_q  <= state_d;
      mc_ptr_q <= mc_ptr_d;
      owner_q  <= owner_d;
      resv_q   <= resv_d;
      for (int o = 0; o < NUM_PORT; o++) rr_ptr_q[o] <= rr_ptr_d[o];
    end
  end

endmodule

// File: tb/tb_quadtree_switch_allocator.sv
// Scoreboard bench for quadtree_switch_allocator: directed vectors push
// expected outputs, a negedge monitor pops and compares.
module tb_quadtree_switch_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req_valid = '0;
  logic [24:0] req_port = '0;
  logic [4:0]  out_ready = '0;
  logic [4:0]  grant;
  logic [4:0]  out_valid;
  logic [14:0] out_sel;
  logic        mc_busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [4:0]  g;
    logic [4:0]  v;
    logic [14:0] s;
    logic        b;
  } exp_t;

  exp_t q[$];

  quadtree_switch_allocator dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_port  (req_port),
    .out_ready (out_ready),
    .grant     (grant),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .mc_busy   (mc_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] rp5(input logic [4:0] p4, p3, p2, p1, p0);
    return {p4, p3, p2, p1, p0};
  endfunction

  function automatic logic [14:0] sel5(input logic [2:0] s4, s3, s2, s1, s0);
    return {s4, s3, s2, s1, s0};
  endfunction

  task automatic step(
    input string       name,
    input logic        r,
    input logic [4:0]  rv,
    input logic [24:0] rp,
    input logic [4:0]  ordy,
    input logic [4:0]  eg,
    input logic [4:0]  ev,
    input logic [14:0] es,
    input logic        eb
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = rv;
    req_port  = rp;
    out_ready = ordy;
    e.name = name;
    e.g = eg;
    e.v = ev;
    e.s = es;
    e.b = eb;
    q.push_back(e);
  endtask

  task automatic do_reset();
    step("reset", 1'b1, 5'h00, '0, 5'h00, 5'h00, 5'h00, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (grant !== e.g || out_valid !== e.v || out_sel !== e.s ||
          mc_busy !== e.b) begin
        fails++;
        $display("FAIL %s: got g=%b v=%b s=%h b=%b, want g=%b v=%b s=%h b=%b",
                 e.name, grant, out_valid, out_sel, mc_busy,
                 e.g, e.v, e.s, e.b);
      end
    end
  end

  initial begin
    logic [24:0] rp;

    // 1 reset holds outputs low, then pointer 0 wins
    rp = rp5(5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001);
    step("rst_hold", 1'b1, 5'h1F, rp, 5'h1F, 5'h00, 5'h00, '0, 1'b0);
    step("rst_rel0", 1'b0, 5'h1F, rp, 5'h1F, 5'h01, 5'h01, '0, 1'b0);
    step("rst_rel1", 1'b0, 5'h1F, rp, 5'h1F, 5'h02, 5'h01,
         sel5(0, 0, 0, 0, 1), 1'b0);

    // 2 round-robin on output 1
    do_reset();
    rp = rp5(5'b00010, 5'b0, 5'b00010, 5'b0, 5'b00010);
    for (int n = 0; n < 2; n++) begin
      step("rr_in0", 1'b0, 5'b10101, rp, 5'h1F, 5'b00001, 5'b00010,
           sel5(0, 0, 0, 0, 0), 1'b0);
      step("rr_in2", 1'b0, 5'b10101, rp, 5'h1F, 5'b00100, 5'b00010,
           sel5(0, 0, 0, 2, 0), 1'b0);
      step("rr_in4", 1'b0, 5'b10101, rp, 5'h1F, 5'b10000, 5'b00010,
           sel5(0, 0, 0, 4, 0), 1'b0);
    end

    // 3 parallel unicast and per-output backpressure
    do_reset();
    rp = rp5(5'b0, 5'b0, 5'b10000, 5'b00010, 5'b00001);
    step("par_all", 1'b0, 5'b00111, rp, 5'h1F, 5'b00111, 5'b10011,
         sel5(2, 0, 0, 1, 0), 1'b0);
    step("par_bp4", 1'b0, 5'b00111, rp, 5'b01111, 5'b00011, 5'b00011,
         sel5(0, 0, 0, 1, 0), 1'b0);

    // 4 multicast reservation blocks unicast until the owner fires
    do_reset();
    rp = rp5(5'b0, 5'b01111, 5'b0, 5'b0, 5'b00001);
    step("mc_c0", 1'b0, 5'b01001, rp, 5'h1F, 5'b00001, 5'b00001, '0, 1'b0);
    step("mc_wait", 1'b0, 5'b01001, rp, 5'b10111, 5'h00, 5'h00, '0, 1'b1);
    step("mc_fire", 1'b0, 5'b01001, rp, 5'h1F, 5'b01000, 5'b01111,
         sel5(0, 3, 3, 3, 3), 1'b1);
    step("mc_after", 1'b0, 5'b00001, rp, 5'h1F, 5'b00001, 5'b00001,
         '0, 1'b0);

    // 5 partial readiness never splits a multicast
    do_reset();
    rp = rp5(5'b0, 5'b0, 5'b0, 5'b00011, 5'b0);
    step("bp_elect", 1'b0, 5'b00010, rp, 5'b00001, 5'h00, 5'h00, '0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      step("bp_01", 1'b0, 5'b00010, rp, 5'b00001, 5'h00, 5'h00, '0, 1'b1);
      step("bp_10", 1'b0, 5'b00010, rp, 5'b00010, 5'h00, 5'h00, '0, 1'b1);
    end
    step("bp_fire", 1'b0, 5'b00010, rp, 5'b00011, 5'b00010, 5'b00011,
         sel5(0, 0, 0, 1, 1), 1'b1);
    step("bp_done", 1'b0, 5'b00000, rp, 5'b00011, 5'h00, 5'h00, '0, 1'b0);

    // 6 reset in the middle of HOLD
    do_reset();
    rp = rp5(5'b0, 5'b0, 5'b00101, 5'b0, 5'b0);
    step("mr_elect", 1'b0, 5'b00100, rp, 5'h00, 5'h00, 5'h00, '0, 1'b0);
    step("mr_hold", 1'b0, 5'b00100, rp, 5'h00, 5'h00, 5'h00, '0, 1'b1);
    step("mr_rst", 1'b1, 5'b00100, rp, 5'h1F, 5'h00, 5'h00, '0, 1'b0);
    step("mr_rel", 1'b0, 5'b00100, rp, 5'h1F, 5'h00, 5'h00, '0, 1'b0);
    step("mr_fire", 1'b0, 5'b00100, rp, 5'h1F, 5'b00100, 5'b00101,
         sel5(0, 0, 2, 0, 2), 1'b1);
    step("mr_done", 1'b0, 5'b00000, rp, 5'h1F, 5'h00, 5'h00, '0, 1'b0);

    // 7 owner changes its route while holding: abort without grant
    do_reset();
    rp = rp5(5'b0, 5'b0, 5'b0, 5'b00110, 5'b0);
    step("ab_elect", 1'b0, 5'b00010, rp, 5'h00, 5'h00, 5'h00, '0, 1'b0);
    rp = rp5(5'b0, 5'b0, 5'b0, 5'b00111, 5'b0);
    step("ab_chg", 1'b0, 5'b00010, rp, 5'h1F, 5'h00, 5'h00, '0, 1'b1);
    step("ab_idle", 1'b0, 5'b00000, rp, 5'h1F, 5'h00, 5'h00, '0, 1'b0);

    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
